// File: rtl/song_player.sv
// Song sequencer: walks the song ROM, plays each note period as a square wave for a
// fixed duration with a silent gap after it. Define SONG_PLAYER_LOOP_EN to repeat the song.
module song_player #(
    parameter int unsigned SONG_LEN    = 26,
    parameter int unsigned NOTE_CYCLES = 3000000,
    parameter int unsigned GAP_CYCLES  = 600000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    output logic [4:0]  rom_addr,
    input  logic [15:0] rom_note,
    output logic        speaker,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DMAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int unsigned DW   = $clog2(DMAX + 1);
    localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_CYCLES - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DW-1:0] DONE_INC  = DW'(1);
    localparam logic [4:0]    IDX_LAST  = 5'(SONG_LEN - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    state_t        state, state_n;
    logic [4:0]    idx, idx_n;
    logic [15:0]   note_reg, note_n;
    logic [15:0]   pcnt, pcnt_n, pcnt_wrap;
    logic [DW-1:0] dcnt, dcnt_n;
    logic          spk_n, done_n, seg_end;

    assign rom_addr  = idx;
    assign busy      = (state != IDLE);
    assign pcnt_wrap = (pcnt == note_reg - 16'd1) ? '0 : pcnt + 16'd1;
    // With no gap the end of PLAY doubles as the end of the note slot.
    assign seg_end   = ((state == GAP) && (dcnt == GAP_LAST)) ||
                       ((state == PLAY) && (dcnt == NOTE_LAST) && (GAP_CYCLES == 0));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        note_n  = note_reg;
        pcnt_n  = pcnt;
        dcnt_n  = dcnt;
        spk_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    idx_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                // Speaker is registered, so the first PLAY cycle's phase is decided here.
                note_n  = rom_note;
                pcnt_n  = '0;
                dcnt_n  = '0;
                spk_n   = (rom_note >= 16'd2);
                state_n = PLAY;
            end
            PLAY: begin
                if (dcnt == NOTE_LAST) begin
                    dcnt_n  = '0;
                    state_n = GAP;
                end else begin
                    dcnt_n = dcnt + DONE_INC;
                    if (note_reg >= 16'd2) begin
                        pcnt_n = pcnt_wrap;
                        spk_n  = (pcnt_wrap < {1'b0, note_reg[15:1]});
                    end else begin
                        pcnt_n = '0;
                    end
                end
            end
            GAP: dcnt_n = dcnt + DONE_INC;
            default: state_n = IDLE;
        endcase

        if (seg_end) begin
            dcnt_n = '0;
            if (idx != IDX_LAST) begin
                idx_n   = idx + 5'd1;
                state_n = FETCH;
            end else begin
                done_n = 1'b1;
`ifdef SONG_PLAYER_LOOP_EN
                idx_n   = '0;
                state_n = FETCH;
`else
                state_n = IDLE;
`endif
            end
        end

        if (stop && (state != IDLE)) begin
            state_n = IDLE;
            spk_n   = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            note_reg <= '0;
            pcnt     <= '0;
            dcnt     <= '0;
            speaker  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            note_reg <= note_n;
            pcnt     <= pcnt_n;
            dcnt     <= dcnt_n;
            speaker  <= spk_n;
            done     <= done_n;
        end
    end

endmodule

// File: doc/song_player.md
Name: song_player

Overview:
- Sequencer that reads the song ROM and drives the speaker pin.
- Walks ROM addresses 0..SONG_LEN-1. For each address it fetches the 16-bit note word, which is the tone period in clk cycles (C = 45866 at 12 MHz).
- Plays a square wave of that period for a fixed duration, then a short silent gap, then advances.
- Sits between the song ROM and the top-level start/stop buttons.

Parameters:
- SONG_LEN, 26, number of ROM entries played (1..32).
- NOTE_CYCLES, 3000000, clk cycles each note sounds (250 ms at 12 MHz); must be >= 1.
- GAP_CYCLES, 600000, silent clk cycles after each note so repeated notes articulate; 0 means no gap.

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; begins playback from address 0 when idle.
- stop  in  1  aborts playback, returns to IDLE.
- rom_addr  out  5  address to song ROM; registered.
- rom_note  in  16  ROM data; valid one clk after rom_addr is stable (synchronous ROM).
- speaker  out  1  square-wave audio output; registered.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the last note's gap completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rom_addr=0, speaker=0, busy=0, done=0.
  - All counters and the note register are cleared.
  - Reset mid-song aborts immediately. After release the block waits in IDLE for start.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE:
  - speaker=0.
  - On start=1 and stop=0: idx<=0, rom_addr<=0, go to FETCH.
- FETCH: one cycle; rom_addr is stable while the ROM registers the word.
- LOAD:
  - One cycle; captures rom_note into note_reg.
  - Clears the period counter pcnt and the duration counter dcnt.
  - Goes to PLAY.
- PLAY:
  - Lasts exactly NOTE_CYCLES cycles.
  - pcnt counts 0..note_reg-1 and wraps to 0.
  - speaker <= (pcnt < note_reg>>1), so speaker is high in the first PLAY cycle of each note. The phase restarts for every note.
  - note_reg < 2 is a rest: speaker held 0 and pcnt held 0.
  - When dcnt reaches NOTE_CYCLES-1: go to GAP, or skip GAP if GAP_CYCLES=0.
- GAP:
  - speaker=0 for exactly GAP_CYCLES cycles.
  - If idx < SONG_LEN-1: idx<=idx+1, rom_addr<=idx+1, go to FETCH.
  - Otherwise: done=1 for one cycle, go to IDLE.
- Latency: start sampled at edge N gives FETCH in cycle N+1, LOAD in N+2, first PLAY cycle in N+3. speaker's registered value appears in cycle N+3's output, aligned with the first PLAY cycle.
- Note-to-note spacing: NOTE_CYCLES + GAP_CYCLES + 2 cycles (FETCH+LOAD silent).
- Arithmetic:
  - pcnt is 16 bits; no overflow is possible since pcnt < note_reg <= 65535.
  - dcnt width is clog2 of max(NOTE_CYCLES, GAP_CYCLES)+1.
  - idx is 5 bits and never exceeds SONG_LEN-1.
- Control edge cases:
  - start while busy: ignored, no restart.
  - stop in any non-IDLE state: next state IDLE, speaker=0 on the next edge, done not pulsed.
  - start and stop asserted in the same cycle: stop wins.
  - start held high continuously: after done, playback restarts (IDLE then FETCH on the next cycle).
- rom_note is only sampled in LOAD. Its value in other states is don't-care.

Optional Feature:
- Macro: SONG_PLAYER_LOOP_EN.
- Defined: at the end of the last GAP, done pulses, then idx<=0, rom_addr<=0 and the state goes directly to FETCH. The song repeats until stop or reset, and busy stays 1.
- Undefined: behaviour is as above; return to IDLE after the last note.

Test Plan (bench uses SONG_LEN=3, NOTE_CYCLES=100, GAP_CYCLES=10, model ROM with 1-cycle latency: addr0=20, addr1=0, addr2=7):
1. Reset, then start pulse at cycle 0 -> rom_addr=0 in cycle 1. speaker=1 from cycle 3 for 10 cycles, 0 for 10 cycles, repeating for 100 cycles (5 full periods). Then 10 gap cycles with speaker=0.
2. Continue scenario 1 -> addr1 (value 0) is a rest: speaker=0 for all 100 PLAY cycles. addr2 (period 7): high 3 cycles, low 4 cycles. done pulses exactly once at cycle 3+3*110+2*2 = 337; busy=0 afterward.
3. Assert stop during addr1 PLAY -> speaker=0 and busy=0 on the next edge, no done pulse. A new start replays from rom_addr=0.
4. Assert start and stop together while idle -> stays IDLE, busy=0. Pulse start again mid-song -> no address reset; the timing of scenario 1 is unchanged.
5. Drop rst_n asynchronously mid-PLAY (between clock edges) -> speaker, busy and rom_addr are 0 immediately. After release, no activity until start.
6. With SONG_PLAYER_LOOP_EN defined -> after done at cycle 337, rom_addr=0 in cycle 338, busy stays 1, and the second pass repeats the waveform of scenario 1 exactly.
